// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU op encoding and statistics counter helpers.
package alu_share_arbiter_pkg;

    typedef enum logic [4:0] {
        ALUOP_nop   = 5'd0,
        ALUOP_add   = 5'd1,
        ALUOP_sub   = 5'd2,
        ALUOP_and   = 5'd3,
        ALUOP_or    = 5'd4,
        ALUOP_xor   = 5'd5,
        ALUOP_sll   = 5'd6,
        ALUOP_srl   = 5'd7,
        ALUOP_sra   = 5'd8,
        ALUOP_slt   = 5'd9,
        ALUOP_sltu  = 5'd10,
        ALUOP_auipc = 5'd11,
        ALUOP_lui   = 5'd12
    } alu_op_e;

    localparam int STAT_W = 16;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == STAT_MAX) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after i_ptr, wrapping modulo NREQ.
module alu_share_arbiter_rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_valid,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_idx,
    output logic            o_any
);

    always_comb begin
        int j;
        j       = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(i_ptr) + k) % NREQ;
            if (!o_any && i_valid[j]) begin
                o_any      = 1'b1;
                o_grant[j] = 1'b1;
                o_idx      = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between NREQ requesters with a one-entry response register.
// Optional per-requester grant and stall counters are built when ALU_SHARE_ARB_STATS_EN is defined.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               flush,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*32-1:0] req_a,
    input  logic [NREQ*32-1:0] req_b,
    input  logic [NREQ*5-1:0]  req_op,
    input  logic [NREQ*32-1:0] req_pc,
    output logic [31:0]        alu_a,
    output logic [31:0]        alu_b,
    output logic [31:0]        alu_pc,
    output logic [4:0]         alu_op,
    input  logic [31:0]        alu_c,
    input  logic               alu_zero,
`ifdef ALU_SHARE_ARB_STATS_EN
    output logic [NREQ*STAT_W-1:0] stat_grant,
    output logic [STAT_W-1:0]      stat_stall,
`endif
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [IDW-1:0]     resp_id,
    output logic [31:0]        resp_c,
    output logic               resp_zero
);

    logic [IDW-1:0]  r_rr_ptr;
    logic            r_resp_valid;
    logic [IDW-1:0]  r_resp_id;
    logic [31:0]     r_resp_c;
    logic            r_resp_zero;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_slot_free;
    logic            w_accept;
    logic [IDW-1:0]  w_ptr_next;

    alu_share_arbiter_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_rr_pick (
        .i_valid (req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Handshake: a requester transfers on a cycle where its req_valid and req_ready are both high;
    // the response transfers where resp_valid and resp_ready are both high. A held response that is
    // being drained frees the slot in the same cycle, so a new op can be accepted with no bubble.
    assign w_slot_free = !r_resp_valid | resp_ready;
    assign w_accept    = w_slot_free & !flush & w_any;
    assign req_ready   = {NREQ{w_accept}} & w_grant;
    assign w_ptr_next  = (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + IDW'(1);

    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_pc = '0;
        alu_op = ALUOP_nop;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                alu_a  = req_a[32*i +: 32];
                alu_b  = req_b[32*i +: 32];
                alu_pc = req_pc[32*i +: 32];
                alu_op = req_op[5*i +: 5];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rr_ptr     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_id    <= '0;
            r_resp_c     <= '0;
            r_resp_zero  <= 1'b0;
        end else if (w_accept) begin
            r_rr_ptr     <= w_ptr_next;
            r_resp_valid <= 1'b1;
            r_resp_id    <= w_idx;
            r_resp_c     <= alu_c;
            r_resp_zero  <= alu_zero;
        end else if (flush | resp_ready) begin
            r_resp_valid <= 1'b0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_id    = r_resp_id;
    assign resp_c     = r_resp_c;
    assign resp_zero  = r_resp_zero;

`ifdef ALU_SHARE_ARB_STATS_EN
    logic [NREQ*STAT_W-1:0] r_stat_grant;
    logic [STAT_W-1:0]      r_stat_stall;

    // Stall counts any cycle with pending requests but no transfer, flush cycles included.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stat_grant <= '0;
            r_stat_stall <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (w_accept && w_grant[i])
                    r_stat_grant[STAT_W*i +: STAT_W] <= sat_inc(r_stat_grant[STAT_W*i +: STAT_W]);
            end
            if (w_any && !w_accept)
                r_stat_stall <= sat_inc(r_stat_stall);
        end
    end

    assign stat_grant = r_stat_grant;
    assign stat_stall = r_stat_stall;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed plus randomized checks of alu_share_arbiter against a cycle-level reference model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int NREQ = 2;
    localparam int IDW  = $clog2(NREQ);
    localparam int RW   = IDW + 33;

    logic               clk;
    logic               rstn;
    logic               flush;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*32-1:0] req_a, req_b, req_pc;
    logic [NREQ*5-1:0]  req_op;
    logic [31:0]        alu_a, alu_b, alu_pc, alu_c;
    logic [4:0]         alu_op;
    logic               alu_zero;
    logic               resp_valid, resp_ready, resp_zero;
    logic [IDW-1:0]     resp_id;
    logic [31:0]        resp_c;
`ifdef ALU_SHARE_ARB_STATS_EN
    logic [NREQ*STAT_W-1:0] stat_grant;
    logic [STAT_W-1:0]      stat_stall;
`endif

    alu_share_arbiter #(.NREQ(NREQ)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .req_pc     (req_pc),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_pc     (alu_pc),
        .alu_op     (alu_op),
        .alu_c      (alu_c),
        .alu_zero   (alu_zero),
`ifdef ALU_SHARE_ARB_STATS_EN
        .stat_grant (stat_grant),
        .stat_stall (stat_stall),
`endif
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_c     (resp_c),
        .resp_zero  (resp_zero)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- requester fields and a behavioural ALU ----------------
    logic [NREQ-1:0] v_r;
    logic [31:0]     a_v [NREQ];
    logic [31:0]     b_v [NREQ];
    logic [31:0]     pc_v[NREQ];
    logic [4:0]      op_v[NREQ];

    function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] pc);
        case (op)
            ALUOP_add:   return a + b;
            ALUOP_sub:   return a - b;
            ALUOP_and:   return a & b;
            ALUOP_or:    return a | b;
            ALUOP_xor:   return a ^ b;
            ALUOP_sll:   return a << b[4:0];
            ALUOP_srl:   return a >> b[4:0];
            ALUOP_sra:   return $signed(a) >>> b[4:0];
            ALUOP_slt:   return {31'b0, $signed(a) < $signed(b)};
            ALUOP_sltu:  return {31'b0, a < b};
            ALUOP_auipc: return pc + b;
            ALUOP_lui:   return b;
            default:     return 32'd0;
        endcase
    endfunction

    always_comb begin
        req_valid = v_r;
        req_a = '0; req_b = '0; req_pc = '0; req_op = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[32*i +: 32]  = a_v[i];
            req_b[32*i +: 32]  = b_v[i];
            req_pc[32*i +: 32] = pc_v[i];
            req_op[5*i +: 5]   = op_v[i];
        end
        alu_c    = alu_fn(alu_op, alu_a, alu_b, alu_pc);
        alu_zero = (alu_c == 32'd0);
    end

    // ---------------- scoreboard and reference model ----------------
    int checks, errors;
    logic [RW-1:0] exp_q[$];
    int          m_ptr;
    bit          m_vld;
    logic [31:0] m_c;
    bit          m_zero;
    int          m_id;
    int          m_grant[NREQ];
    int          m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0; m_vld = 0; m_c = 0; m_zero = 0; m_id = 0; m_stall = 0;
        for (int i = 0; i < NREQ; i++) m_grant[i] = 0;
        exp_q.delete();
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drv(input int i, input bit v, input logic [4:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc);
        v_r[i] = v; op_v[i] = op; a_v[i] = a; b_v[i] = b; pc_v[i] = pc;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NREQ; i++) drv(i, 0, ALUOP_nop, 0, 0, 0);
    endtask

    // One clock: check combinational outputs, advance the model, check registered outputs.
    task automatic cycle();
        int w;
        bit acc;
        logic [NREQ-1:0] exp_rdy;
        logic [RW-1:0] e;
        #1;
        w   = pick(v_r, m_ptr);
        acc = (w >= 0) && (!m_vld || resp_ready) && !flush;
        exp_rdy = '0;
        if (acc) exp_rdy[w] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (w >= 0) begin
            chk("alu_a", alu_a, a_v[w]);
            chk("alu_b", alu_b, b_v[w]);
            chk("alu_pc", alu_pc, pc_v[w]);
            chk("alu_op", 32'(alu_op), 32'(op_v[w]));
        end else begin
            chk("alu_op_idle", 32'(alu_op), 32'(ALUOP_nop));
            chk("alu_a_idle", alu_a, 32'd0);
        end
        if (acc) begin
            m_c    = alu_fn(op_v[w], a_v[w], b_v[w], pc_v[w]);
            m_zero = (m_c == 32'd0);
            m_id   = w;
            m_vld  = 1;
            m_ptr  = (w + 1) % NREQ;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            exp_q.push_back({IDW'(w), m_zero, m_c});
            if (m_grant[w] < 65535) m_grant[w]++;
        end else begin
            if (w >= 0 && m_stall < 65535) m_stall++;
            if ((flush || resp_ready) && m_vld) begin
                m_vld = 0;
                void'(exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(m_vld));
        if (m_vld && exp_q.size() > 0) begin
            e = exp_q[0];
            chk("resp_c", resp_c, e[31:0]);
            chk("resp_zero", 32'(resp_zero), 32'(e[32]));
            chk("resp_id", 32'(resp_id), 32'(e[RW-1:33]));
        end else begin
            chk("resp_c_kept", resp_c, m_c);
            chk("resp_id_kept", 32'(resp_id), 32'(m_id));
        end
`ifdef ALU_SHARE_ARB_STATS_EN
        for (int i = 0; i < NREQ; i++)
            chk("stat_grant", 32'(stat_grant[STAT_W*i +: STAT_W]), 32'(m_grant[i]));
        chk("stat_stall", 32'(stat_stall), 32'(m_stall));
`endif
    endtask

    // ---------------- directed and random stimulus ----------------
    initial begin
        logic [31:0] held_c;
        checks = 0; errors = 0;
        rstn = 1'b0; flush = 1'b0; resp_ready = 1'b0;
        v_r = '0;
        idle_all();
        model_reset();
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(ALUOP_nop));
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_resp_c", resp_c, 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        cycle();

        // single op on requester 0
        resp_ready = 1'b1;
        drv(0, 1, ALUOP_add, 32'd5, 32'd7, 32'h100);
        cycle();
        chk("single_c", resp_c, 32'd12);
        chk("single_id", 32'(resp_id), 32'd0);
        chk("single_zero", 32'(resp_zero), 32'd0);
        idle_all();

        // asynchronous reset while a response is held
        #2 rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(resp_valid), 32'd0);
        chk("midrst_c", resp_c, 32'd0);
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;

        // contention: alternating grants starting at requester 0
        drv(0, 1, ALUOP_add, 32'd1, 32'd2, 32'h200);
        drv(1, 1, ALUOP_sub, 32'd3, 32'd3, 32'h300);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("grant_order", 32'(resp_id), 32'(k % 2));
            if (k % 2 == 1) begin
                chk("sub_c", resp_c, 32'd0);
                chk("sub_zero", 32'(resp_zero), 32'd1);
            end
        end

        // backpressure holds the response and blocks all grants
        resp_ready = 1'b0;
        held_c = resp_c;
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("bp_hold_c", resp_c, held_c);
        end
        resp_ready = 1'b1;
        drv(0, 0, ALUOP_nop, 0, 0, 0);
        drv(1, 1, ALUOP_or, 32'h0f0, 32'h00f, 32'h400);
        cycle();
        chk("drain_accept_valid", 32'(resp_valid), 32'd1);
        chk("drain_accept_c", resp_c, 32'h0ff);

        // flush kills the held response and blocks issue
        idle_all();
        drv(0, 1, ALUOP_xor, 32'h55, 32'h0f, 32'h500);
        resp_ready = 1'b0;
        flush = 1'b1;
        cycle();
        chk("flush_valid", 32'(resp_valid), 32'd0);
        flush = 1'b0;
        cycle();
        chk("after_flush_id", 32'(resp_id), 32'd0);
        chk("after_flush_c", resp_c, 32'h5a);

        // randomized traffic
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                logic [31:0] a;
                a = $urandom;
                drv(i, $urandom_range(0, 2) != 0, 5'($urandom_range(0, 12)), a,
                    ($urandom_range(0, 3) == 0) ? a : 32'($urandom), $urandom);
            end
            flush      = ($urandom_range(0, 9) == 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        flush = 1'b0;

`ifdef ALU_SHARE_ARB_STATS_EN
        rstn = 1'b0;
        idle_all();
        model_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
        resp_ready = 1'b1;
        drv(0, 1, ALUOP_add, 32'd1, 32'd1, 0);
        drv(1, 1, ALUOP_add, 32'd2, 32'd2, 0);
        for (int k = 0; k < 4; k++) cycle();
        drv(1, 0, ALUOP_nop, 0, 0, 0);
        cycle();
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        chk("stats_grant_pair", stat_grant, {16'd2, 16'd3});
        chk("stats_stall4", 32'(stat_stall), 32'd4);
        resp_ready = 1'b1;
        repeat (70000) @(posedge clk);
        #1;
        chk("stats_sat0", 32'(stat_grant[15:0]), 32'hffff);
        chk("stats_sat1", 32'(stat_grant[31:16]), 32'd2);
        chk("stats_stall_kept", 32'(stat_stall), 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single integer ALU between NREQ requesters, e.g. the execute stage (id 0) and the branch-compare/AGU path (id 1).
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Drives the ALU operand/op/PC inputs from the winner and captures ALU result and Zero into a one-entry response register with its own valid/ready handshake.
- Sits between decode/issue and the ALU, in place of direct ALU wiring.

Parameters:
- NREQ, 2, number of requesters; legal range 2..8.
- IDW, $clog2(NREQ), width of the requester id.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- flush  input  1  pipeline flush; kills held response, blocks issue this cycle.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  NREQ*32  operand A, requester i in bits [32i+31:32i].
- req_b  input  NREQ*32  operand B, same packing.
- req_op  input  NREQ*5  ALU op code (shared ALUOP_* encoding), packing [5i+4:5i].
- req_pc  input  NREQ*32  PC for auipc, same packing as req_a.
- alu_a, alu_b, alu_pc  output  32 each  to ALU A, B, PC.
- alu_op  output  5  to ALU ALUop.
- alu_c  input  32  ALU result C.
- alu_zero  input  1  ALU Zero.
- resp_valid  output  1  response held.
- resp_ready  input  1  consumer takes response.
- resp_id  output  IDW  id of the requester that produced the response.
- resp_c  output  32  registered result.
- resp_zero  output  1  registered Zero.

Behaviour:
- Reset (async, rstn=0): resp_valid=0, resp_c=0, resp_zero=0, resp_id=0, rr_ptr=0; all counters 0.
- slot_free = !resp_valid | resp_ready.
- Winner: first i with req_valid[i], scanning from rr_ptr upward with wrap modulo NREQ.
- Grant: req_ready[winner]=1 iff slot_free & !flush & any valid. All req_ready bits are 0 otherwise. req_ready is combinational from valids, rr_ptr, resp state and flush.
- ALU drive: alu_a/b/op/pc equal the winner's fields whenever any req_valid is set. Otherwise alu_op=ALUOP_nop and alu_a=alu_b=alu_pc=0.
- Accept (req_valid&req_ready): next edge loads resp_c<=alu_c, resp_zero<=alu_zero, resp_id<=winner, resp_valid<=1, rr_ptr<=(winner+1) mod NREQ.
- rr_ptr moves only on accept; it must not move on stall or flush.
- Latency: exactly 1 cycle from accept to resp_valid.
- Throughput: one op per cycle when resp_ready is held high.
- Backpressure: resp_valid=1 & resp_ready=0 holds resp_* stable and all req_ready=0.
- Drain with new accept in the same cycle: the new response replaces the old one with no bubble.
- Drain without a new accept: resp_valid<=0.
- Flush: next edge resp_valid<=0 and no accept this cycle, regardless of resp_ready. resp_c, resp_zero and resp_id keep their values.
- Requester contract: once req_valid is asserted, fields stay stable until accepted. The arbiter must not depend on this for correctness.
- Reset mid-operation: the pending response is discarded; state returns to reset values immediately.

Optional Feature:
- Macro ALU_SHARE_ARB_STATS_EN.
- With the macro: adds output stat_grant  NREQ*16, one saturating 16-bit accept counter per requester, packing [16i+15:16i]. Also adds output stat_stall  16, a saturating count of cycles with any req_valid and no accept (flush cycles included). Counters hold at 16'hFFFF.
- Without the macro: both ports and all counter logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package/header holds the ALUOP_* codes, ALUOP_nop, and the localparam for stat counter width.
- One natural sub-module: rr_pick. Inputs: NREQ valid vector and rr_ptr. Outputs: one-hot grant, winner index and any. It is purely combinational and reused by other shared-resource arbiters.

Test Plan:
- Reset then idle → resp_valid=0, all req_ready=0, alu_op=ALUOP_nop, alu_a=0.
- Single op: req0 add A=5 B=7 with resp_ready=1 → req_ready[0]=1, next cycle resp_valid=1 resp_id=0 resp_c=12 resp_zero=0.
- Contention: both valid every cycle for 4 cycles with resp_ready=1 → grant order 0,1,0,1. Check req1 sub A=3 B=3 gives resp_c=0 resp_zero=1.
- Backpressure: response held with resp_ready=0 for 3 cycles → resp_c stable, req_ready=0, rr_ptr unchanged. resp_ready=1 with req1 valid → drain plus accept in the same cycle, no bubble.
- Flush with resp_valid=1 and req0 valid → next cycle resp_valid=0 and no accept. Following cycle req0 is accepted.
- Stats (macro on): 3 accepts req0, 2 accepts req1, 4 stall cycles → stat_grant={16'd2,16'd3}, stat_stall=4. Forced 70000 accepts → stat_grant[0] saturates at 16'hFFFF.
